ext_mem_stream_source: RTL
==========================

Name: ext_mem_stream_source

Overview:
- Transmitter side of the a/b operand streams consumed by top_chip.
- Reads a contiguous region of external memory through a pseudo-2-port read port: read_en/read_addr, qout valid one cycle later.
- Unpacks each memory word into IO_DATA_WIDTH elements and drives them out on a valid/ready stream, honouring backpressure.
- Instantiated in top_system, or in the bench, once per operand stream (a_input, b_input).

Parameters:
- IO_DATA_WIDTH, 16: width of one streamed element.
- EXT_MEM_WIDTH, 32: memory word width. Must be an integer multiple of IO_DATA_WIDTH.
- EXT_MEM_HEIGHT, 1<<20: memory depth. Address width is $clog2(EXT_MEM_HEIGHT).
- LEN_WIDTH, 32: width of the element-count input.

Ports:
- clk, input, 1: system clock.
- arst_n_in, input, 1: asynchronous reset, active low.
- start, input, 1: single-cycle request. Sampled only in IDLE.
- base_addr, input, $clog2(EXT_MEM_HEIGHT): first word address. Sampled with start.
- length, input, LEN_WIDTH: number of elements to stream. Sampled with start.
- running, output, 1: high from the cycle after start is accepted until the done cycle, inclusive.
- done, output, 1: one-cycle pulse after the last element handshake.
- ext_mem_read_addr, output, $clog2(EXT_MEM_HEIGHT): read address.
- ext_mem_read_en, output, 1: read strobe.
- ext_mem_qout, input, EXT_MEM_WIDTH: read data, valid the cycle after read_en.
- data_out, output, IO_DATA_WIDTH: streamed element.
- data_valid, output, 1: data_out holds a valid element.
- data_ready, input, 1: consumer accepts. A transfer happens when data_valid and data_ready are both high.

Behaviour:
- LANES = EXT_MEM_WIDTH/IO_DATA_WIDTH. Lane 0 is bits [IO_DATA_WIDTH-1:0] and is emitted first.
- Reset: all outputs 0. FSM in IDLE; FIFO empty; counters 0; any in-flight read discarded.
- Reset asserted mid-transfer aborts the transfer. No done pulse is produced.
- FSM states: IDLE, STREAM, DONE.
- IDLE: start=1 latches base_addr and length.
  - length==0: go to DONE. No reads are issued.
  - Otherwise go to STREAM.
- STREAM: issues ceil(length/LANES) reads at base_addr, base_addr+1, and so on.
  - Addresses wrap modulo EXT_MEM_HEIGHT.
- DONE: done=1 for exactly one cycle, then return to IDLE.
  - The length==0 case follows the same path: done pulses 2 cycles after start.
- start while not in IDLE is ignored.
- Buffering: 2-entry FIFO of memory words. Read data is written into the FIFO the cycle after read_en.
- Read issue rule: read_en=1 when reads remain and (fifo_count + inflight - pop_this_cycle) < 2. The FIFO never overflows.
- Output path:
  - data_valid = FIFO non-empty and elements remain.
  - data_out = lane[lane_idx] of the FIFO head.
- On each transfer:
  - lane_idx increments.
  - The head is popped when lane_idx==LANES-1 or when this is the last element.
  - lane_idx then returns to 0.
- Unused lanes of the final word are never emitted.
- Stream rules:
  - data_valid, once high, stays high until the transfer; it never depends on data_ready.
  - data_out is stable while data_valid=1 and data_ready=0.
  - data_out is don't-care when data_valid=0.
- Latency, start sampled at cycle 0:
  - running=1 from cycle 1.
  - First read_en at cycle 1; its qout arrives at cycle 2.
  - First data_valid at cycle 3.
- Throughput: with data_ready held high, one element per cycle is sustained for any LANES ≥ 1.
- Last transfer at cycle N: done=1 and running=1 at cycle N+1; running=0 at cycle N+2.
- The element counter is LEN_WIDTH bits. The read counter is sized for ceil((2^LEN_WIDTH-1)/LANES).

Decomposition:
- Package ext_mem_stream_pkg holds:
  - the state enum typedef (IDLE/STREAM/DONE);
  - the LANES derivation;
  - a lane-index width function.
- Sub-module stream_word_fifo: 2-entry synchronous FIFO with push/pop/count and the same reset rules.
  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.

Test Plan:
- Preload mem[10]=0xBBBB_AAAA, mem[11]=0xDDDD_CCCC; start base_addr=10, length=4, data_ready=1 -> data_out AAAA,BBBB,CCCC,DDDD on cycles 3..6; exactly 2 reads; done at cycle 7.
- Same preload, length=3 -> outputs AAAA,BBBB,CCCC; 2 reads; DDDD never emitted; done one cycle after the CCCC transfer.
- length=0 -> no read_en, data_valid never high, done pulses at cycle 2.
- length=8 with data_ready toggling 1,0,0,1 repeating -> data_out stable across stalls; no element lost or duplicated; at most 2 words buffered plus 1 in flight.
- base_addr=EXT_MEM_HEIGHT-1, length=4 -> reads at EXT_MEM_HEIGHT-1 then 0; order preserved.
- Reset pulsed during STREAM of length=16, then start length=2 -> no done from the aborted transfer; the second transfer completes normally with fresh data.

Source files
------------

// File: rtl/ext_mem_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_stream_pkg
// Description : Shared types and helpers for the external-memory stream source.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_mem_stream_pkg;

  // Controller states with a fixed 2-bit encoding so the register width is explicit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_e;

  // Number of stream elements packed in one memory word.
  function automatic int calc_lanes(input int mem_width, input int io_width);
    return mem_width / io_width;
  endfunction

  // Width of the lane index register; never narrower than one bit.
  function automatic int lane_idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_word_fifo
// Description : Two-entry synchronous FIFO holding fetched memory words.
//               Push and pop together on a full FIFO keep the count unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_word_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic w_push;
  logic w_pop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign w_push = push && ((r_count != 2'd2) || pop);
  assign w_pop  = pop && (r_count != 2'd0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0   <= '0;
      r_mem1   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wr_ptr) r_mem1 <= push_data;
        else          r_mem0 <= push_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_rd_ptr ? r_mem1 : r_mem0;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ext_mem_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_stream_source
// Description : Reads a contiguous external-memory region and streams it out
//               lane by lane (lane 0 first) on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_stream_source
  import ext_mem_stream_pkg::*;
#(
  parameter int IO_DATA_WIDTH  = 16,
  parameter int EXT_MEM_WIDTH  = 32,
  parameter int EXT_MEM_HEIGHT = 1 << 20,
  parameter int LEN_WIDTH      = 32
) (
  input  logic                              clk,
  input  logic                              arst_n_in,
  input  logic                              start,
  input  logic [$clog2(EXT_MEM_HEIGHT)-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]              length,
  output logic                              running,
  output logic                              done,
  output logic [$clog2(EXT_MEM_HEIGHT)-1:0] ext_mem_read_addr,
  output logic                              ext_mem_read_en,
  input  logic [EXT_MEM_WIDTH-1:0]          ext_mem_qout,
  output logic [IO_DATA_WIDTH-1:0]          data_out,
  output logic                              data_valid,
  input  logic                              data_ready
);

  localparam int LANES = calc_lanes(EXT_MEM_WIDTH, IO_DATA_WIDTH);
  localparam int LIW   = lane_idx_width(LANES);
  localparam int AW    = $clog2(EXT_MEM_HEIGHT);

  localparam logic [LEN_WIDTH-1:0] C_LANES     = LEN_WIDTH'(LANES);
  localparam logic [LEN_WIDTH-1:0] C_ONE       = LEN_WIDTH'(1);
  localparam logic [LIW-1:0]       C_LAST_LANE = LIW'(LANES - 1);
  localparam logic [AW-1:0]        C_LAST_ADDR = AW'(EXT_MEM_HEIGHT - 1);

  stream_state_e        r_state;
  logic                 r_zero_len;   // holds DONE one extra cycle for an empty request
  logic [AW-1:0]        r_addr;
  logic [LEN_WIDTH-1:0] r_elems_left;
  logic [LEN_WIDTH-1:0] r_reads_left;
  logic [LIW-1:0]       r_lane;
  logic                 r_inflight;

  logic [EXT_MEM_WIDTH-1:0] w_head;
  logic [1:0]               w_fifo_count;
  logic [2:0]               w_occupancy;
  logic [LEN_WIDTH-1:0]     w_rd_quot;
  logic [LEN_WIDTH-1:0]     w_rd_rem;
  logic [LEN_WIDTH-1:0]     w_rd_init;
  logic                     w_valid;
  logic                     w_xfer;
  logic                     w_last;
  logic                     w_pop;
  logic                     w_read;
  logic [IO_DATA_WIDTH-1:0] w_lanes [LANES];

  // Number of word reads needed: ceil(length / LANES) without risking overflow.
  assign w_rd_quot = length / C_LANES;
  assign w_rd_rem  = length % C_LANES;
  assign w_rd_init = w_rd_quot + LEN_WIDTH'(w_rd_rem != '0);

  assign w_valid = (r_state == STREAM) && (w_fifo_count != 2'd0) && (r_elems_left != '0);
  assign w_xfer  = w_valid && data_ready;
  assign w_last  = (r_elems_left == C_ONE);
  assign w_pop   = w_xfer && ((r_lane == C_LAST_LANE) || w_last);

  // Words that will occupy the FIFO once everything in flight lands; a pop
  // implies a non-empty FIFO so this never underflows.
  assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_read      = (r_state == STREAM) && (r_reads_left != '0) && (w_occupancy < 3'd2);

  // Controller state, address/element/read counters and lane position.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state      <= IDLE;
      r_zero_len   <= 1'b0;
      r_addr       <= '0;
      r_elems_left <= '0;
      r_reads_left <= '0;
      r_lane       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr       <= base_addr;
            r_elems_left <= length;
            r_reads_left <= w_rd_init;
            r_lane       <= '0;
            if (length == '0) begin
              r_state    <= DONE;
              r_zero_len <= 1'b1;
            end else begin
              r_state    <= STREAM;
            end
          end
        end
        STREAM: begin
          if (w_read) begin
            r_addr       <= (r_addr == C_LAST_ADDR) ? '0 : r_addr + AW'(1);
            r_reads_left <= r_reads_left - C_ONE;
          end
          if (w_xfer) begin
            r_elems_left <= r_elems_left - C_ONE;
            r_lane       <= w_pop ? '0 : r_lane + LIW'(1);
            if (w_last) r_state <= DONE;
          end
        end
        DONE: begin
          if (r_zero_len) r_zero_len <= 1'b0;
          else            r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Remembers that a read was issued so its data is captured next cycle.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) r_inflight <= 1'b0;
    else            r_inflight <= w_read;
  end

  stream_word_fifo #(
    .WIDTH (EXT_MEM_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (arst_n_in),
    .push      (r_inflight),
    .push_data (ext_mem_qout),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_fifo_count)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lanes
    assign w_lanes[g] = w_head[g*IO_DATA_WIDTH +: IO_DATA_WIDTH];
  end

  assign data_out          = w_lanes[r_lane];
  assign data_valid        = w_valid;
  assign ext_mem_read_en   = w_read;
  assign ext_mem_read_addr = r_addr;
  assign running           = (r_state != IDLE);
  assign done              = (r_state == DONE) && !r_zero_len;

endmodule
`default_nettype wire
